// File: rtl/tmds_channel_decoder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tmds_channel_decoder
//
// Receive-side decoder for one TMDS colour channel. Each pixclk it takes one
// 10-bit word from the deserializer and recovers either 8-bit video data
// (VDE=1) or a 2-bit control code (VDE=0). An alignment state machine looks
// for runs of control tokens during blanking to confirm word boundaries. If
// no qualifying run shows up in time, it pulses bitslip so the deserializer
// shifts its word boundary by one bit.
//
// Ports
//   pixclk      in   1   pixel clock, all logic on the rising edge
//   reset       in   1   asynchronous active-high reset; release is
//                        expected to be synchronous to pixclk
//   tmds_in     in  10   parallel TMDS word, bit 0 first on the wire
//   VD          out  8   decoded video data (held during control periods)
//   CD          out  2   decoded control code (held during data periods)
//   VDE         out  1   1 = data period, 0 = control period
//   bitslip     out  1   one-cycle request to slip alignment by one bit
//   locked      out  1   word alignment established
//   slip_count  out  4   slips issued since reset, modulo 10
// ---------------------------------------------------------------------------
module tmds_channel_decoder #(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int SLIP_SETTLE    = 16,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic       pixclk,
    input  logic       reset,
    input  logic [9:0] tmds_in,
    output logic [7:0] VD,
    output logic [1:0] CD,
    output logic       VDE,
    output logic       bitslip,
    output logic       locked,
    output logic [3:0] slip_count
);

    // SEARCH and LOCKED share one timer, so it is sized for the longer
    // of the two timeouts.
    localparam int TIMER_SPAN = (LOCK_TIMEOUT > SEARCH_TIMEOUT) ? LOCK_TIMEOUT : SEARCH_TIMEOUT;
    localparam int RUN_W      = $clog2(CTRL_RUN) + 1;
    localparam int TIMER_W    = $clog2(TIMER_SPAN) + 1;
    localparam int SETTLE_W   = $clog2(SLIP_SETTLE) + 1;

    localparam logic [RUN_W-1:0]    RUN_MAX     = RUN_W'(CTRL_RUN);
    localparam logic [TIMER_W-1:0]  SEARCH_LAST = TIMER_W'(SEARCH_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0]  LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SLIP_SETTLE - 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [RUN_W-1:0]    runCnt_q,   runCnt_d;
    logic [TIMER_W-1:0]  timer_q,    timer_d;
    logic [SETTLE_W-1:0] settle_q,   settle_d;
    logic [3:0]          slipCnt_q,  slipCnt_d;
    logic                bitslip_q,  bitslip_d;
    logic                locked_q,   locked_d;
    logic [7:0]          vd_q,       vd_d;
    logic [1:0]          cd_q,       cd_d;
    logic                vde_q,      vde_d;

    logic                isToken;
    logic [1:0]          tokenCode;
    logic [7:0]          qWord;
    logic [7:0]          dataWord;
    logic [RUN_W-1:0]    runNext;
    logic                runHit;

    // The four control tokens are recognised only on an exact match; any
    // other word, including a corrupted token, is treated as video data.
    always_comb begin
        isToken   = 1'b1;
        tokenCode = 2'b00;
        case (tmds_in)
            10'b1101010100: tokenCode = 2'b00;
            10'b0010101011: tokenCode = 2'b01;
            10'b0101010100: tokenCode = 2'b10;
            10'b1010101011: tokenCode = 2'b11;
            default:        isToken   = 1'b0;
        endcase
    end

    // Undo the transmitter's two steps: bit 9 says whether the low byte was
    // inverted, bit 8 says whether the chain was built with XOR or XNOR.
    always_comb begin
        qWord       = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0];
        dataWord    = '0;
        dataWord[0] = qWord[0];
        for (int i = 1; i < 8; i++) begin
            dataWord[i] = tmds_in[8] ? (qWord[i] ^ qWord[i-1]) : ~(qWord[i] ^ qWord[i-1]);
        end
    end

    // Decoded outputs are registered one cycle behind the input. Whichever
    // of VD/CD does not apply to the current word keeps its last value.
    always_comb begin
        vd_d  = vd_q;
        cd_d  = cd_q;
        vde_d = 1'b0;
        if (isToken) begin
            cd_d = tokenCode;
        end else begin
            vd_d  = dataWord;
            vde_d = 1'b1;
        end
    end

    // Run length of consecutive tokens, counted against the word being
    // sampled now. The token codes may change within a run, so any token
    // extends it. The count saturates so that a long blanking interval
    // keeps reporting a hit.
    always_comb begin
        if (!isToken) begin
            runNext = '0;
        end else if (runCnt_q == RUN_MAX) begin
            runNext = runCnt_q;
        end else begin
            runNext = runCnt_q + RUN_W'(1);
        end
        runHit = (runNext == RUN_MAX);
    end

    // Alignment FSM next-state logic. Lock is judged on the count that
    // includes the current word, so locked rises one cycle after the token
    // that completes the run, in step with the decoded outputs.
    // slip_count advances as SLIP is entered so that it rises together
    // with the bitslip pulse.
    always_comb begin
        state_d   = state_q;
        runCnt_d  = runNext;
        timer_d   = timer_q;
        settle_d  = settle_q;
        slipCnt_d = slipCnt_q;

        unique case (state_q)
            ST_SEARCH: begin
                timer_d = timer_q + TIMER_W'(1);
                if (runHit) begin
                    state_d = ST_LOCKED;
                    timer_d = '0;
                end else if (timer_q == SEARCH_LAST) begin
                    state_d   = ST_SLIP;
                    timer_d   = '0;
                    slipCnt_d = (slipCnt_q == 4'd9) ? 4'd0 : slipCnt_q + 4'd1;
                end
            end

            ST_SLIP: begin
                runCnt_d = '0;
                timer_d  = '0;
                settle_d = '0;
                state_d  = ST_SETTLE;
            end

            ST_SETTLE: begin
                runCnt_d = '0;
                timer_d  = '0;
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = ST_SEARCH;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end

            ST_LOCKED: begin
                if (runHit) begin
                    timer_d = '0;
                end else if (timer_q == LOCK_LAST) begin
                    state_d  = ST_SEARCH;
                    timer_d  = '0;
                    runCnt_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            default: begin
                state_d  = ST_SEARCH;
                runCnt_d = '0;
                timer_d  = '0;
                settle_d = '0;
            end
        endcase

        bitslip_d = (state_d == ST_SLIP);
        locked_d  = (state_d == ST_LOCKED);
    end

    // All state, including the bitslip and locked flags, lives in flops
    // cleared by the asynchronous reset. Registering the flags directly
    // avoids decode glitches on the outputs, and bitslip drops the moment
    // reset is asserted.
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SEARCH;
            runCnt_q  <= '0;
            timer_q   <= '0;
            settle_q  <= '0;
            slipCnt_q <= '0;
            bitslip_q <= 1'b0;
            locked_q  <= 1'b0;
            vd_q      <= '0;
            cd_q      <= '0;
            vde_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            runCnt_q  <= runCnt_d;
            timer_q   <= timer_d;
            settle_q  <= settle_d;
            slipCnt_q <= slipCnt_d;
            bitslip_q <= bitslip_d;
            locked_q  <= locked_d;
            vd_q      <= vd_d;
            cd_q      <= cd_d;
            vde_q     <= vde_d;
        end
    end

    assign VD         = vd_q;
    assign CD         = cd_q;
    assign VDE        = vde_q;
    assign bitslip    = bitslip_q;
    assign locked     = locked_q;
    assign slip_count = slipCnt_q;

endmodule
